// File: rtl/picture_uart_tx.sv
// Frame readback: reads every pixel from picture memory and sends it as three 8N1 bytes (R, G, B).
// Latency: start -> first start bit in 4 cycles; no backpressure, uart_tx runs at a fixed bit rate.
module picture_uart_tx #(
    parameter int CLKS_PER_BIT = 100,
    parameter int NUM_PIXELS   = 307200,
    parameter int ADDR_W       = 19
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    input  logic [17:0]       mem_rgb,
    output logic              uart_tx,
    output logic              busy,
    output logic              done
);

    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0]     T_LAST   = TW'(CLKS_PER_BIT - 1);
    localparam logic [ADDR_W-1:0] PIX_LAST = ADDR_W'(NUM_PIXELS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_LOAD,
        S_START_BIT,
        S_DATA_BITS,
        S_STOP_BIT,
        S_DONE
    } state_t;

    state_t            state;
    logic [TW-1:0]     bit_timer;
    logic [2:0]        bit_cnt;
    logic [1:0]        byte_idx;
    logic [ADDR_W-1:0] pix_idx;
    logic [7:0]        tx_byte;
    logic [11:0]       pix_gb;
    logic              bit_last;

    assign bit_last = (bit_timer == T_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            bit_timer <= '0;
            bit_cnt   <= '0;
            byte_idx  <= '0;
            pix_idx   <= '0;
            tx_byte   <= '0;
            pix_gb    <= '0;
            mem_addr  <= '0;
            mem_rd_en <= 1'b0;
            uart_tx   <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state inside {S_START_BIT, S_DATA_BITS, S_STOP_BIT}) begin
                bit_timer <= bit_last ? '0 : bit_timer + 1'b1;
            end else begin
                bit_timer <= '0;
            end

            case (state)
                S_IDLE: begin
                    uart_tx <= 1'b1;
                    if (start) begin
                        state     <= S_READ;
                        busy      <= 1'b1;
                        mem_rd_en <= 1'b1;
                        mem_addr  <= pix_idx;
                    end
                end
                S_READ: begin
                    mem_rd_en <= 1'b0;
                    state     <= S_WAIT;
                end
                S_WAIT: state <= S_LOAD;
                S_LOAD: begin
                    // R goes out first; G and B wait in pix_gb until their byte slot.
                    tx_byte  <= {2'b00, mem_rgb[17:12]};
                    pix_gb   <= mem_rgb[11:0];
                    byte_idx <= '0;
                    uart_tx  <= 1'b0;
                    state    <= S_START_BIT;
                end
                S_START_BIT: begin
                    if (bit_last) begin
                        bit_cnt <= '0;
                        uart_tx <= tx_byte[0];
                        state   <= S_DATA_BITS;
                    end
                end
                S_DATA_BITS: begin
                    if (bit_last) begin
                        if (bit_cnt == 3'd7) begin
                            uart_tx <= 1'b1;
                            state   <= S_STOP_BIT;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                            uart_tx <= tx_byte[1];
                            tx_byte <= {1'b0, tx_byte[7:1]};
                        end
                    end
                end
                S_STOP_BIT: begin
                    if (bit_last) begin
                        if (byte_idx != 2'd2) begin
                            byte_idx <= byte_idx + 2'd1;
                            tx_byte  <= (byte_idx == 2'd0) ? {2'b00, pix_gb[11:6]}
                                                           : {2'b00, pix_gb[5:0]};
                            uart_tx  <= 1'b0;
                            state    <= S_START_BIT;
                        end else if (pix_idx != PIX_LAST) begin
                            pix_idx   <= pix_idx + 1'b1;
                            mem_addr  <= pix_idx + 1'b1;
                            mem_rd_en <= 1'b1;
                            state     <= S_READ;
                        end else begin
                            pix_idx <= '0;
                            done    <= 1'b1;
                            busy    <= 1'b0;
                            state   <= S_DONE;
                        end
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_picture_uart_tx.sv
// Directed bench for picture_uart_tx: three instances (1 pixel, 2 pixels, full-rate timing).
module tb_picture_uart_tx;

    localparam int AW = 19;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset_n;
    logic          start_one, start_two, start_slow;
    logic [17:0]   rgb_one, rgb_two, rgb_slow;
    logic          tx_one, tx_two, tx_slow;
    logic          busy_one, busy_two, busy_slow;
    logic          done_one, done_two, done_slow;
    logic          rd_one, rd_two, rd_slow;
    logic [AW-1:0] addr_one, addr_two, addr_slow;

    logic [17:0] mem_one, mem_slow;
    logic [17:0] mem_two [2];

    picture_uart_tx #(.CLKS_PER_BIT(4), .NUM_PIXELS(1), .ADDR_W(AW)) u_one (
        .clk(clk), .reset_n(reset_n), .start(start_one), .mem_addr(addr_one),
        .mem_rd_en(rd_one), .mem_rgb(rgb_one), .uart_tx(tx_one), .busy(busy_one), .done(done_one));

    picture_uart_tx #(.CLKS_PER_BIT(4), .NUM_PIXELS(2), .ADDR_W(AW)) u_two (
        .clk(clk), .reset_n(reset_n), .start(start_two), .mem_addr(addr_two),
        .mem_rd_en(rd_two), .mem_rgb(rgb_two), .uart_tx(tx_two), .busy(busy_two), .done(done_two));

    picture_uart_tx #(.CLKS_PER_BIT(100), .NUM_PIXELS(1), .ADDR_W(AW)) u_slow (
        .clk(clk), .reset_n(reset_n), .start(start_slow), .mem_addr(addr_slow),
        .mem_rd_en(rd_slow), .mem_rgb(rgb_slow), .uart_tx(tx_slow), .busy(busy_slow), .done(done_slow));

    // Synchronous-read memory models: data appears the cycle after the strobe.
    always @(posedge clk) if (rd_one)  rgb_one  <= mem_one;
    always @(posedge clk) if (rd_two)  rgb_two  <= mem_two[addr_two[0]];
    always @(posedge clk) if (rd_slow) rgb_slow <= mem_slow;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int sel = 0;
    int cpb = 4;
    int checks = 0;
    int failures = 0;

    logic          tx_obs, busy_obs, done_obs, rd_obs;
    logic [AW-1:0] addr_obs;
    always_comb begin
        tx_obs = tx_one; busy_obs = busy_one; done_obs = done_one; rd_obs = rd_one; addr_obs = addr_one;
        case (sel)
            1: begin tx_obs = tx_two; busy_obs = busy_two; done_obs = done_two; rd_obs = rd_two; addr_obs = addr_two; end
            2: begin tx_obs = tx_slow; busy_obs = busy_slow; done_obs = done_slow; rd_obs = rd_slow; addr_obs = addr_slow; end
            default: ;
        endcase
    end

    logic [AW-1:0] addr_q [$];
    always @(negedge clk) if (rd_obs === 1'b1) addr_q.push_back(addr_obs);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_start(input logic v);
        case (sel)
            0:       start_one  = v;
            1:       start_two  = v;
            default: start_slow = v;
        endcase
    endtask

    task automatic pulse_start(output int t0);
        set_start(1'b1);
        t0 = cyc;
        @(negedge clk);
        set_start(1'b0);
    endtask

    task automatic wait_fall(output int fall, output int idle);
        logic seen;
        seen = 1'b0; idle = 0; fall = 0;
        for (int i = 0; i < 5000; i++) begin
            if (tx_obs === 1'b0) begin
                seen = 1'b1;
                fall = cyc;
                break;
            end
            idle++;
            @(negedge clk);
        end
        check("start_bit_seen", {31'd0, seen}, 32'd1);
    endtask

    // Checks the whole 10-bit frame cycle by cycle, then decodes data at mid-bit.
    task automatic recv_rest(input logic [7:0] exp, input string tag);
        int bad, b;
        logic e;
        logic [7:0] got;
        bad = 0; got = '0;
        for (int k = 0; k < 10 * cpb; k++) begin
            if (k > 0) @(negedge clk);
            b = k / cpb;
            e = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : exp[b-1];
            if (tx_obs !== e) bad++;
            if (b >= 1 && b <= 8 && (k % cpb) == cpb / 2) got[b-1] = tx_obs;
        end
        @(negedge clk);
        check({tag, "_data"}, {24'd0, got}, {24'd0, exp});
        check({tag, "_frame_bad_cycles"}, bad, 0);
    endtask

    task automatic recv_byte(input logic [7:0] exp, input string tag, output int fall, output int idle);
        wait_fall(fall, idle);
        recv_rest(exp, tag);
    endtask

    task automatic recv_pix(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                            input string tag, output int f_first, output int idle_first);
        int fa, fb, fc, ia, ib, ic;
        recv_byte(b0, {tag, "_b0"}, fa, ia);
        recv_byte(b1, {tag, "_b1"}, fb, ib);
        check({tag, "_b1_idle"}, ib, 0);
        recv_byte(b2, {tag, "_b2"}, fc, ic);
        check({tag, "_b2_idle"}, ic, 0);
        check({tag, "_byte_period"}, fb - fa, 10 * cpb);
        f_first = fa;
        idle_first = ia;
    endtask

    task automatic wait_done(output int dc);
        logic seen;
        seen = 1'b0; dc = 0;
        for (int i = 0; i < 5000; i++) begin
            if (done_obs === 1'b1) begin
                seen = 1'b1;
                dc = cyc;
                break;
            end
            @(negedge clk);
        end
        check("done_seen", {31'd0, seen}, 32'd1);
    endtask

    task automatic two_pixel_body(input string tag, input int t0);
        int fa, ia, dc;
        recv_pix(8'h00, 8'h3F, 8'h3F, {tag, "_p0"}, fa, ia);
        check({tag, "_first_fall"}, fa - t0, 4);
        recv_pix(8'h15, 8'h15, 8'h15, {tag, "_p1"}, fa, ia);
        check({tag, "_pixel_gap"}, ia, 3);
        wait_done(dc);
        check({tag, "_done_time"}, dc - t0, 1 + 2 * 123);
    endtask

    task automatic check_addrs(input string tag);
        check({tag, "_addr_count"}, addr_q.size(), 2);
        if (addr_q.size() == 2) begin
            check({tag, "_addr0"}, {13'd0, addr_q[0]}, 32'd0);
            check({tag, "_addr1"}, {13'd0, addr_q[1]}, 32'd1);
        end
    endtask

    initial begin
        int t0, fa, ia, dc;
        reset_n = 1'b0;
        start_one = 1'b0; start_two = 1'b0; start_slow = 1'b0;
        mem_one    = 18'h3F01F;
        mem_two[0] = 18'h00FFF;
        mem_two[1] = 18'h15555;
        mem_slow   = 18'h2A5C3;

        // Reset state
        sel = 1; cpb = 4;
        repeat (3) @(negedge clk);
        check("rst_tx", {31'd0, tx_obs}, 32'd1);
        check("rst_busy", {31'd0, busy_obs}, 32'd0);
        check("rst_done", {31'd0, done_obs}, 32'd0);
        check("rst_rd_en", {31'd0, rd_obs}, 32'd0);
        check("rst_addr", {13'd0, addr_obs}, 32'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_tx", {31'd0, tx_obs}, 32'd1);
        check("idle_busy", {31'd0, busy_obs}, 32'd0);

        // Single pixel 3F01F -> 3F 00 1F
        sel = 0; cpb = 4;
        pulse_start(t0);
        check("one_rd_en_t1", {31'd0, rd_obs}, 32'd1);
        check("one_busy_t1", {31'd0, busy_obs}, 32'd1);
        recv_pix(8'h3F, 8'h00, 8'h1F, "one", fa, ia);
        check("one_first_fall", fa - t0, 4);
        wait_done(dc);
        check("one_done_time", dc - t0, 124);
        check("one_busy_at_done", {31'd0, busy_obs}, 32'd0);
        @(negedge clk);
        check("one_done_width", {31'd0, done_obs}, 32'd0);

        // Two pixels
        sel = 1; cpb = 4;
        addr_q.delete();
        pulse_start(t0);
        check("two_rd_en_t1", {31'd0, rd_obs}, 32'd1);
        two_pixel_body("two", t0);
        @(negedge clk);
        check("two_done_width", {31'd0, done_obs}, 32'd0);
        check_addrs("two");

        // Repeated starts while busy, plus a start coinciding with done
        addr_q.delete();
        pulse_start(t0);
        fork
            two_pixel_body("rep", t0);
            begin
                repeat (6) begin
                    repeat (30) @(negedge clk);
                    set_start(1'b1);
                    @(negedge clk);
                    set_start(1'b0);
                end
            end
        join
        set_start(1'b1);
        @(negedge clk);
        set_start(1'b0);
        repeat (4) @(negedge clk);
        check("rep_busy_after_done_start", {31'd0, busy_obs}, 32'd0);
        check("rep_tx_idle", {31'd0, tx_obs}, 32'd1);
        check_addrs("rep");

        // Reset during data bit 6 (a zero) of byte1
        addr_q.delete();
        pulse_start(t0);
        recv_byte(8'h00, "rst_b0", fa, ia);
        wait_fall(fa, ia);
        repeat (7 * cpb) @(negedge clk);
        check("rst_pre_tx", {31'd0, tx_obs}, 32'd0);
        reset_n = 1'b0;
        #1;
        check("rst_async_tx", {31'd0, tx_obs}, 32'd1);
        check("rst_async_busy", {31'd0, busy_obs}, 32'd0);
        check("rst_async_rd_en", {31'd0, rd_obs}, 32'd0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        addr_q.delete();
        pulse_start(t0);
        check("rst_again_addr", {13'd0, addr_obs}, 32'd0);
        two_pixel_body("rst_again", t0);
        check_addrs("rst_again");

        // Full-rate timing: 100 clocks per bit, 2A5C3 -> 2A 17 03
        sel = 2; cpb = 100;
        pulse_start(t0);
        recv_pix(8'h2A, 8'h17, 8'h03, "slow", fa, ia);
        check("slow_first_fall", fa - t0, 4);
        wait_done(dc);
        check("slow_done_time", dc - t0, 1 + 30 * 100 + 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
